// File: rtl/clint_bus_arbiter.sv
// Round-robin arbiter for two requesters onto the CLINT slave bus, with a
// grant lock that keeps 64-bit mtime/mtimecmp low/high word pairs atomic.
module clint_bus_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned SIZE_WIDTH     = 2,
    parameter int unsigned REG_DATA_WIDTH = 32,
    parameter int unsigned BUS_DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] MTIME_ADDR    = ADDR_WIDTH'('hbff8),
    parameter logic [ADDR_WIDTH-1:0] MTIMECMP_ADDR = ADDR_WIDTH'('h4000),
    parameter int unsigned LOCK_TIMEOUT   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     m0_read_addr,
    input  logic [ADDR_WIDTH-1:0]     m0_write_addr,
    input  logic [SIZE_WIDTH-1:0]     m0_read_size,
    input  logic [SIZE_WIDTH-1:0]     m0_write_size,
    input  logic [REG_DATA_WIDTH-1:0] m0_data,
    input  logic                      m0_rd,
    input  logic                      m0_wr,
    output logic                      m0_grant,
    output logic [BUS_DATA_WIDTH-1:0] m0_rdata,
    output logic                      m0_rvalid,
    input  logic [ADDR_WIDTH-1:0]     m1_read_addr,
    input  logic [ADDR_WIDTH-1:0]     m1_write_addr,
    input  logic [SIZE_WIDTH-1:0]     m1_read_size,
    input  logic [SIZE_WIDTH-1:0]     m1_write_size,
    input  logic [REG_DATA_WIDTH-1:0] m1_data,
    input  logic                      m1_rd,
    input  logic                      m1_wr,
    output logic                      m1_grant,
    output logic [BUS_DATA_WIDTH-1:0] m1_rdata,
    output logic                      m1_rvalid,
    output logic [ADDR_WIDTH-1:0]     bus_clint_read_addr,
    output logic [ADDR_WIDTH-1:0]     bus_clint_write_addr,
    output logic [SIZE_WIDTH-1:0]     bus_clint_read_size,
    output logic [SIZE_WIDTH-1:0]     bus_clint_write_size,
    output logic [REG_DATA_WIDTH-1:0] bus_clint_data,
    output logic                      bus_clint_rd,
    output logic                      bus_clint_wr,
    input  logic [BUS_DATA_WIDTH-1:0] clint_bus_data,
    output logic                      arb_locked
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOCK_TIMEOUT);
    localparam logic [ADDR_WIDTH-1:0] MTIME_HI    = MTIME_ADDR + ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] MTIMECMP_HI = MTIMECMP_ADDR + ADDR_WIDTH'(4);

    logic             rr_ptr_q, rr_ptr_d;
    logic             locked_q, locked_d;
    logic             lock_owner_q, lock_owner_d;
    logic             lock_reg_q, lock_reg_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             rd_pend_q, rd_pend_d;
    logic             rd_owner_q, rd_owner_d;

    logic req0, req1, any_gnt;
    logic hit_time, hit_cmp, hit_hi;
    logic [ADDR_WIDTH-1:0] hi_addr;

    assign req0    = m0_rd | m0_wr;
    assign req1    = m1_rd | m1_wr;
    assign any_gnt = m0_grant | m1_grant;

    // While locked only the owner may win, even if it is idle.
    always_comb begin
        m0_grant = 1'b0;
        m1_grant = 1'b0;
        if (!rst) begin
            if (locked_q) begin
                m0_grant = req0 & ~lock_owner_q;
                m1_grant = req1 &  lock_owner_q;
            end else begin
                m0_grant = req0 & (~req1 | ~rr_ptr_q);
                m1_grant = req1 & (~req0 |  rr_ptr_q);
            end
        end
    end

    always_comb begin
        bus_clint_read_addr  = '0;
        bus_clint_write_addr = '0;
        bus_clint_read_size  = '0;
        bus_clint_write_size = '0;
        bus_clint_data       = '0;
        bus_clint_rd         = 1'b0;
        bus_clint_wr         = 1'b0;
        if (m0_grant) begin
            bus_clint_read_addr  = m0_read_addr;
            bus_clint_write_addr = m0_write_addr;
            bus_clint_read_size  = m0_read_size;
            bus_clint_write_size = m0_write_size;
            bus_clint_data       = m0_data;
            bus_clint_rd         = m0_rd;
            bus_clint_wr         = m0_wr;
        end else if (m1_grant) begin
            bus_clint_read_addr  = m1_read_addr;
            bus_clint_write_addr = m1_write_addr;
            bus_clint_read_size  = m1_read_size;
            bus_clint_write_size = m1_write_size;
            bus_clint_data       = m1_data;
            bus_clint_rd         = m1_rd;
            bus_clint_wr         = m1_wr;
        end
    end

    assign hi_addr  = lock_reg_q ? MTIMECMP_HI : MTIME_HI;
    assign hit_time = (bus_clint_rd && bus_clint_read_addr == MTIME_ADDR) ||
                      (bus_clint_wr && bus_clint_write_addr == MTIME_ADDR);
    assign hit_cmp  = (bus_clint_rd && bus_clint_read_addr == MTIMECMP_ADDR) ||
                      (bus_clint_wr && bus_clint_write_addr == MTIMECMP_ADDR);
    assign hit_hi   = (bus_clint_rd && bus_clint_read_addr == hi_addr) ||
                      (bus_clint_wr && bus_clint_write_addr == hi_addr);

    // Low-word hits take priority over a concurrent high-word release.
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        locked_d     = locked_q;
        lock_owner_d = lock_owner_q;
        lock_reg_d   = lock_reg_q;
        lock_cnt_d   = lock_cnt_q;
        rd_pend_d    = bus_clint_rd;
        rd_owner_d   = bus_clint_rd ? m1_grant : rd_owner_q;

        if (any_gnt && !locked_q) begin
            rr_ptr_d = m0_grant;
        end

        if (any_gnt && (hit_time || hit_cmp)) begin
            locked_d     = 1'b1;
            lock_owner_d = m1_grant;
            lock_reg_d   = ~hit_time;
            lock_cnt_d   = CNT_INIT;
        end else if (locked_q) begin
            if ((any_gnt && hit_hi) || lock_cnt_q <= CNT_W'(1)) begin
                locked_d   = 1'b0;
                lock_cnt_d = '0;
                rr_ptr_d   = ~lock_owner_q;
            end else begin
                lock_cnt_d = lock_cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q     <= 1'b0;
            locked_q     <= 1'b0;
            lock_owner_q <= 1'b0;
            lock_reg_q   <= 1'b0;
            lock_cnt_q   <= '0;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            locked_q     <= locked_d;
            lock_owner_q <= lock_owner_d;
            lock_reg_q   <= lock_reg_d;
            lock_cnt_q   <= lock_cnt_d;
            rd_pend_q    <= rd_pend_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    assign m0_rvalid  = rd_pend_q & ~rd_owner_q;
    assign m1_rvalid  = rd_pend_q &  rd_owner_q;
    assign m0_rdata   = m0_rvalid ? clint_bus_data : '0;
    assign m1_rdata   = m1_rvalid ? clint_bus_data : '0;
    assign arb_locked = locked_q;

endmodule

// File: tb/tb_clint_bus_arbiter.sv
// Directed bench for clint_bus_arbiter: vector table for arbitration and
// read return, hand sequences for lock timeout, re-arm and mid-read reset.
module tb_clint_bus_arbiter;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] m0_read_addr, m0_write_addr, m1_read_addr, m1_write_addr;
    logic [1:0]  m0_read_size, m0_write_size, m1_read_size, m1_write_size;
    logic [31:0] m0_data, m1_data;
    logic        m0_rd, m0_wr, m1_rd, m1_wr;
    logic        m0_grant, m1_grant, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [15:0] bus_clint_read_addr, bus_clint_write_addr;
    logic [1:0]  bus_clint_read_size, bus_clint_write_size;
    logic [31:0] bus_clint_data;
    logic        bus_clint_rd, bus_clint_wr;
    logic [31:0] clint_bus_data;
    logic        arb_locked;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    clint_bus_arbiter #(.LOCK_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .m0_read_addr(m0_read_addr), .m0_write_addr(m0_write_addr),
        .m0_read_size(m0_read_size), .m0_write_size(m0_write_size),
        .m0_data(m0_data), .m0_rd(m0_rd), .m0_wr(m0_wr),
        .m0_grant(m0_grant), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_read_addr(m1_read_addr), .m1_write_addr(m1_write_addr),
        .m1_read_size(m1_read_size), .m1_write_size(m1_write_size),
        .m1_data(m1_data), .m1_rd(m1_rd), .m1_wr(m1_wr),
        .m1_grant(m1_grant), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .bus_clint_read_addr(bus_clint_read_addr),
        .bus_clint_write_addr(bus_clint_write_addr),
        .bus_clint_read_size(bus_clint_read_size),
        .bus_clint_write_size(bus_clint_write_size),
        .bus_clint_data(bus_clint_data),
        .bus_clint_rd(bus_clint_rd), .bus_clint_wr(bus_clint_wr),
        .clint_bus_data(clint_bus_data),
        .arb_locked(arb_locked)
    );

    typedef struct packed {
        logic        r0, w0;
        logic [15:0] a0;
        logic        r1, w1;
        logic [15:0] a1;
        logic        g0, g1, v0, v1, lk;
    } vec_t;

    vec_t tbl [17];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [69:0] act_bus();
        return {bus_clint_read_addr, bus_clint_write_addr, bus_clint_read_size,
                bus_clint_write_size, bus_clint_data, bus_clint_rd, bus_clint_wr};
    endfunction

    function automatic logic [69:0] exp_bus(input logic g0, input logic g1);
        if (g0)
            return {m0_read_addr, m0_write_addr, m0_read_size, m0_write_size,
                    m0_data, m0_rd, m0_wr};
        if (g1)
            return {m1_read_addr, m1_write_addr, m1_read_size, m1_write_size,
                    m1_data, m1_rd, m1_wr};
        return '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        clint_bus_data = $urandom;
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [15:0] ra0,
                         input logic [15:0] wa0, input logic r1, input logic w1,
                         input logic [15:0] ra1, input logic [15:0] wa1);
        m0_rd = r0; m0_wr = w0; m0_read_addr = ra0; m0_write_addr = wa0;
        m0_data = {16'ha0a0, wa0};
        m1_rd = r1; m1_wr = w1; m1_read_addr = ra1; m1_write_addr = wa1;
        m1_data = {16'hb1b1, wa1};
    endtask

    task automatic idle();
        drive(F, F, 16'h0, 16'h0, F, F, 16'h0, 16'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        m0_read_size = 2'd2; m0_write_size = 2'd1;
        m1_read_size = 2'd3; m1_write_size = 2'd2;
        clint_bus_data = 32'h0;
        rst = 1'b1;
        drive(T, F, 16'h0, 16'h0, T, F, 16'h0, 16'h0);

        //         r0 w0 a0        r1 w1 a1        g0 g1 v0 v1 lk
        tbl[0]  = {T, F, 16'h0000, T, F, 16'h0000, T, F, F, F, F};
        tbl[1]  = {T, F, 16'h0000, T, F, 16'h0000, F, T, T, F, F};
        tbl[2]  = {T, F, 16'h0000, T, F, 16'h0000, T, F, F, T, F};
        tbl[3]  = {T, F, 16'h0000, T, F, 16'h0000, F, T, T, F, F};
        tbl[4]  = {F, F, 16'h0000, F, F, 16'h0000, F, F, F, T, F};
        tbl[5]  = {F, F, 16'h0000, T, F, 16'h0008, F, T, F, F, F};
        tbl[6]  = {F, T, 16'h0004, F, F, 16'h0000, T, F, F, T, F};
        tbl[7]  = {T, F, 16'h0004, F, F, 16'h0000, T, F, F, F, F};
        tbl[8]  = {F, F, 16'h0000, F, F, 16'h0000, F, F, T, F, F};
        tbl[9]  = {F, T, 16'hbff8, F, F, 16'h0000, T, F, F, F, F};
        tbl[10] = {F, F, 16'h0000, T, F, 16'h0000, F, F, F, F, T};
        tbl[11] = {F, T, 16'hbffc, T, F, 16'h0000, T, F, F, F, T};
        tbl[12] = {F, F, 16'h0000, T, F, 16'h0000, F, T, F, F, F};
        tbl[13] = {F, F, 16'h0000, F, F, 16'h0000, F, F, F, T, F};
        tbl[14] = {F, F, 16'h0000, T, F, 16'h4004, F, T, F, F, F};
        tbl[15] = {T, F, 16'h0000, T, F, 16'h0000, T, F, F, T, F};
        tbl[16] = {F, F, 16'h0000, F, F, 16'h0000, F, F, T, F, F};

        // Reset with both requesters active.
        tick();
        tick();
        @(negedge clk);
        chk1("rst_g0", m0_grant, F);
        chk1("rst_g1", m1_grant, F);
        chk1("rst_rv0", m0_rvalid, F);
        chk1("rst_rv1", m1_rvalid, F);
        chk1("rst_lock", arb_locked, F);
        chkw("rst_bus", 128'(act_bus()), 128'(0));
        chkw("rst_rdata", 128'({m0_rdata, m1_rdata}), 128'(0));
        tick();
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].a0,
                  tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].a1);
            @(negedge clk);
            chk1($sformatf("v%0d_g0", i), m0_grant, tbl[i].g0);
            chk1($sformatf("v%0d_g1", i), m1_grant, tbl[i].g1);
            chk1($sformatf("v%0d_rv0", i), m0_rvalid, tbl[i].v0);
            chk1($sformatf("v%0d_rv1", i), m1_rvalid, tbl[i].v1);
            chk1($sformatf("v%0d_lock", i), arb_locked, tbl[i].lk);
            chkw($sformatf("v%0d_rdata0", i), 128'(m0_rdata),
                 128'(tbl[i].v0 ? clint_bus_data : 32'h0));
            chkw($sformatf("v%0d_rdata1", i), 128'(m1_rdata),
                 128'(tbl[i].v1 ? clint_bus_data : 32'h0));
            chkw($sformatf("v%0d_bus", i), 128'(act_bus()),
                 128'(exp_bus(tbl[i].g0, tbl[i].g1)));
            tick();
        end

        // Lock timeout: m0 reads mtimecmp low word then goes idle.
        do_reset();
        drive(T, F, 16'h4000, 16'h4000, T, F, 16'h0, 16'h0);
        @(negedge clk);
        chk1("to_g0", m0_grant, T);
        chk1("to_g1", m1_grant, F);
        tick();
        drive(F, F, 16'h0, 16'h0, T, F, 16'h0, 16'h0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk1($sformatf("to_wait%0d_g1", k), m1_grant, F);
            chk1($sformatf("to_wait%0d_lock", k), arb_locked, T);
            if (k == 1) begin
                chk1("to_rv0", m0_rvalid, T);
                chkw("to_rdata0", 128'(m0_rdata), 128'(clint_bus_data));
            end
            tick();
        end
        drive(T, F, 16'h0, 16'h0, T, F, 16'h0, 16'h0);
        @(negedge clk);
        chk1("to_rel_g1", m1_grant, T);
        chk1("to_rel_g0", m0_grant, F);
        chk1("to_rel_lock", arb_locked, F);
        tick();

        // Re-arm: mtime high-word read with concurrent mtimecmp low-word write.
        do_reset();
        drive(T, F, 16'hbff8, 16'hbff8, F, F, 16'h0, 16'h0);
        @(negedge clk);
        chk1("ra_g0", m0_grant, T);
        tick();
        drive(T, T, 16'hbffc, 16'h4000, T, F, 16'h0, 16'h0);
        @(negedge clk);
        chk1("ra_both_g0", m0_grant, T);
        chk1("ra_both_g1", m1_grant, F);
        chk1("ra_both_lock", arb_locked, T);
        tick();
        drive(F, T, 16'h0, 16'hbffc, T, F, 16'h0, 16'h0);
        @(negedge clk);
        chk1("ra_oldhi_g0", m0_grant, T);
        chk1("ra_oldhi_lock", arb_locked, T);
        tick();
        drive(F, F, 16'h0, 16'h0, T, F, 16'h0, 16'h0);
        for (int k = 3; k <= 5; k++) begin
            @(negedge clk);
            chk1($sformatf("ra_hold%0d_g1", k), m1_grant, F);
            chk1($sformatf("ra_hold%0d_lock", k), arb_locked, T);
            tick();
        end
        @(negedge clk);
        chk1("ra_rel_g1", m1_grant, T);
        chk1("ra_rel_lock", arb_locked, F);
        tick();

        // Reset while an m1 read response is pending.
        do_reset();
        drive(F, F, 16'h0, 16'h0, T, F, 16'h0, 16'h0);
        @(negedge clk);
        chk1("mr_g1", m1_grant, T);
        tick();
        drive(T, F, 16'h0, 16'h0, F, F, 16'h0, 16'h0);
        #1;
        chk1("mr_pre_rv1", m1_rvalid, T);
        chkw("mr_pre_rdata1", 128'(m1_rdata), 128'(clint_bus_data));
        rst = 1'b1;
        #1;
        chk1("mr_rst_rv1", m1_rvalid, F);
        chkw("mr_rst_rdata1", 128'(m1_rdata), 128'(0));
        chk1("mr_rst_g0", m0_grant, F);
        tick();
        tick();
        rst = 1'b0;
        idle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk1($sformatf("mr_post%0d_rv0", k), m0_rvalid, F);
            chk1($sformatf("mr_post%0d_rv1", k), m1_rvalid, F);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clint_bus_arbiter.md
# clint_bus_arbiter

Arbitrates two bus requesters (core LSU on port 0, debug/DMA on port 1) onto the single CLINT slave bus. Each cycle at most one requester is forwarded to the slave, chosen round-robin. A lock prevents torn 64-bit `mtime`/`mtimecmp` accesses by holding the grant between the low-word and high-word accesses. Read data is returned to the requester that issued the read.

## Interface
Parameters:
- `MTIME_ADDR`, default `'hbff8`: low-word address of `mtime`; high word is `+4`.
- `MTIMECMP_ADDR`, default `'h4000`: low-word address of `mtimecmp`; high word is `+4`.
- `LOCK_TIMEOUT`, default 8: number of cycles a lock may stay open without a high-word access. Range 1..255.

Ports (N = 0, 1):
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `mN_read_addr` / `mN_write_addr`  in  `ADDR_WIDTH`  requester read/write address.
- `mN_read_size` / `mN_write_size`  in  `SIZE_WIDTH`  access size.
- `mN_data`  in  `REG_DATA_WIDTH`  write data.
- `mN_rd` / `mN_wr`  in  1  read/write request.
- `mN_grant`  out  1  access forwarded this cycle (combinational).
- `mN_rdata`  out  `BUS_DATA_WIDTH`  read data.
- `mN_rvalid`  out  1  `mN_rdata` valid.
- `bus_clint_read_addr`, `bus_clint_write_addr`, `bus_clint_read_size`, `bus_clint_write_size`, `bus_clint_data`, `bus_clint_rd`, `bus_clint_wr`  out  widths as the CLINT  slave-side bus.
- `clint_bus_data`  in  `BUS_DATA_WIDTH`  slave read data; valid the cycle after the read is presented.
- `arb_locked`  out  1  lock active (status only).

## Operation
- Request: `reqN = mN_rd | mN_wr`. A requester holds all its signals stable until `mN_grant` is seen.
- Registered state:
  - `rr_ptr`: preferred requester.
  - `locked` and `lock_owner`.
  - `lock_reg`: 0 = `mtime`, 1 = `mtimecmp`.
  - `lock_cnt`: 8 bits.
  - `rd_pend` and `rd_owner`.
- Grant when unlocked:
  - If only one requester is requesting, it is granted.
  - If both are requesting, `rr_ptr` is granted.
- Grant when locked: only `lock_owner` may be granted. The other requester waits, even when the owner is idle.
- Pointer update: after any grant while unlocked, `rr_ptr` becomes the non-granted requester.
- Slave bus:
  - The granted requester's fields are forwarded unchanged.
  - With no grant, all `bus_clint_*` outputs are 0.
- Read return:
  - A granted `rd` sets `rd_pend`=1 and `rd_owner`=granted for the next cycle.
  - During that cycle, `m{rd_owner}_rvalid`=1 and `m{rd_owner}_rdata`=`clint_bus_data`.
  - The other requester's `rdata` is 0.
- Lock detection:
  - Active addresses are `read_addr` if `rd`, and `write_addr` if `wr`.
  - A hit on `MTIME_ADDR` or `MTIMECMP_ADDR` by the granted requester sets, next cycle: `locked`=1, `lock_owner`=that requester, `lock_reg`=the register hit, `lock_cnt`=`LOCK_TIMEOUT`.
- Lock release:
  - Release on a granted owner access hitting `lock_reg`'s high word (`+4`). `locked` clears next cycle.
  - Release when `lock_cnt` reaches 0. `lock_cnt` decrements each locked cycle without a high-word hit.
  - On release, `rr_ptr` becomes the other requester.
- Simultaneous high-word hit and low-word hit (rd vs wr) in one cycle: the low-word hit wins. The lock re-arms with the new `lock_reg` and a full count.
- A high-word access while unlocked is an ordinary access; it does not lock.
- A low-word hit while already locked by the same owner re-arms `lock_cnt`.

## Timing
- Reset values:
  - All outputs are 0.
  - `rr_ptr`=0, `locked`=0, `rd_pend`=0, `lock_cnt`=0.
- Grant latency: 0 cycles. Grant and bus forwarding are combinational from requests and registered state.
- Read latency: `rvalid` is asserted exactly 1 cycle after the granted read. Back-to-back granted reads give `rvalid` every cycle.
- Writes take effect in the CLINT at the granting edge. There is no write acknowledge beyond `mN_grant`.
- Timeout: a lock taken at edge T, with no high-word hit afterwards, is released at edge T+`LOCK_TIMEOUT`. The other requester may be granted in the following cycle.
- Reset mid-operation: clears the lock and any pending `rvalid` immediately (asynchronously). The in-flight read response is lost.

## Test plan
- **Reset:** assert `rst` with both requests high -> both grants 0, all `bus_clint_*` 0, `rvalid` 0.
- **Contention:** both requesters continuously read `MSIP` (addr 0) -> grants alternate 0, 1, 0, 1. Each `mN_rvalid` pulses the cycle after its grant with `rdata`=`clint_bus_data`.
- **Lock by write:** m0 writes `MTIME_ADDR` = `'hffffffff` while m1 requests -> m1 is not granted. Then m0 writes `MTIME_ADDR+4` = `'h5a` -> `arb_locked` drops next cycle, m1 is granted in the cycle after the high-word access.
- **Lock timeout:** `LOCK_TIMEOUT`=4, m0 reads `MTIMECMP_ADDR` then idles, m1 requesting -> m1 is first granted 5 cycles after the m0 grant, and `rr_ptr`=1.
- **Re-arm:** in the same cycle, m0 reads `MTIME_ADDR+4` and writes `MTIMECMP_ADDR` while locked on `mtime` -> lock stays, `lock_reg`=`mtimecmp`, `lock_cnt`=`LOCK_TIMEOUT`.
- **Mid-read reset:** assert `rst` the cycle after a granted m1 read -> `m1_rvalid` is 0 immediately, and no `rvalid` appears after reset is released.
